// File: rtl/sudoku_constraint_checker_if.sv
// Cell stream handshake between the grid loader (master) and the constraint checker (slave).
interface sudoku_constraint_checker_if #(
  parameter int VAL_W = 4
);
  logic             cell_valid;
  logic [VAL_W-1:0] cell_value;
  logic             cell_ready;

  modport master (output cell_valid, output cell_value, input cell_ready);
  modport slave  (input cell_valid, input cell_value, output cell_ready);
endinterface

// File: rtl/sudoku_constraint_checker.sv
// Streams a row-major 9x9 grid and flags the first duplicate in any row, column or 3x3 box.
// Optional macro SUDOKU_FULL_EN: treat empty cells (value 0) as an incomplete-grid violation.
module sudoku_constraint_checker #(
  parameter int VAL_W   = 4,
  parameter int N_CELLS = 81
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  sudoku_constraint_checker_if.slave cell_if,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 err_kind,
  output logic [3:0]                 err_row,
  output logic [3:0]                 err_col,
  output logic [6:0]                 cell_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [2:0] KIND_NONE  = 3'b000;
  localparam logic [2:0] KIND_ROW   = 3'b001;
  localparam logic [2:0] KIND_COL   = 3'b010;
  localparam logic [2:0] KIND_BOX   = 3'b011;
  localparam logic [2:0] KIND_ILLEG = 3'b100;
`ifdef SUDOKU_FULL_EN
  localparam logic [2:0] KIND_EMPTY = 3'b101;
`endif

  state_t           state;
  logic             cell_ready_q;
  logic [3:0]       row_cnt;
  logic [3:0]       col_cnt;
  logic [1:0]       rb;
  logic [1:0]       cb;
  logic [1:0]       rb_sub;
  logic [1:0]       cb_sub;
  logic [8:0]       row_mask [0:8];
  logic [8:0]       col_mask [0:8];
  logic [8:0]       box_mask [0:8];

  logic [VAL_W-1:0] v;
  logic [3:0]       box_idx;
  logic [8:0]       dbit;
  logic             is_digit;
  logic             hs;
  logic             hit_row;
  logic             hit_col;
  logic             hit_box;
  logic [2:0]       cell_kind;

  assign cell_if.cell_ready = cell_ready_q;

  // Classification of the cell currently on the bus against the masks built so far
  always_comb begin
    v         = cell_if.cell_value;
    box_idx   = {1'b0, rb, 1'b0} + {2'b00, rb} + {2'b00, cb};
    is_digit  = (v != '0) && (v <= VAL_W'(9));
    dbit      = 9'd1 << (v - VAL_W'(1));
    hit_row   = |(row_mask[row_cnt] & dbit);
    hit_col   = |(col_mask[col_cnt] & dbit);
    hit_box   = |(box_mask[box_idx] & dbit);
    hs        = cell_if.cell_valid && cell_ready_q;
    cell_kind = KIND_NONE;
    if (v >= VAL_W'(10)) begin
      cell_kind = KIND_ILLEG;
    end else if (v == '0) begin
`ifdef SUDOKU_FULL_EN
      cell_kind = KIND_EMPTY;
`else
      cell_kind = KIND_NONE;
`endif
    end else if (hit_row) begin
      cell_kind = KIND_ROW;
    end else if (hit_col) begin
      cell_kind = KIND_COL;
    end else if (hit_box) begin
      cell_kind = KIND_BOX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      // start behaves like reset except that it lands in SCAN; a coincident cell is dropped
      state        <= rst ? IDLE : SCAN;
      busy         <= !rst;
      cell_ready_q <= !rst;
      done         <= 1'b0;
      err          <= 1'b0;
      err_kind     <= KIND_NONE;
      err_row      <= '0;
      err_col      <= '0;
      cell_count   <= '0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      rb           <= '0;
      cb           <= '0;
      rb_sub       <= '0;
      cb_sub       <= '0;
      for (int i = 0; i < 9; i++) begin
        row_mask[i] <= '0;
        col_mask[i] <= '0;
        box_mask[i] <= '0;
      end
    end else begin
      case (state)
        SCAN: begin
          if (hs) begin
            cell_count <= cell_count + 7'd1;
            if (cell_kind != KIND_NONE) begin
              err <= 1'b1;
              if (!err) begin
                err_kind <= cell_kind;
                err_row  <= row_cnt;
                err_col  <= col_cnt;
              end
            end
            if (is_digit) begin
              row_mask[row_cnt] <= row_mask[row_cnt] | dbit;
              col_mask[col_cnt] <= col_mask[col_cnt] | dbit;
              box_mask[box_idx] <= box_mask[box_idx] | dbit;
            end
            // Position advance: row/col plus mod-3 box coordinates, no division needed
            if (col_cnt == 4'd8) begin
              col_cnt <= '0;
              cb      <= '0;
              cb_sub  <= '0;
              row_cnt <= row_cnt + 4'd1;
              if (rb_sub == 2'd2) begin
                rb_sub <= '0;
                rb     <= rb + 2'd1;
              end else begin
                rb_sub <= rb_sub + 2'd1;
              end
            end else begin
              col_cnt <= col_cnt + 4'd1;
              if (cb_sub == 2'd2) begin
                cb_sub <= '0;
                cb     <= cb + 2'd1;
              end else begin
                cb_sub <= cb_sub + 2'd1;
              end
            end
            if (cell_count == 7'(N_CELLS - 1)) begin
              state        <= DONE;
              busy         <= 1'b0;
              cell_ready_q <= 1'b0;
              done         <= 1'b1;
            end
          end
        end
        DONE: begin
          cell_ready_q <= 1'b0;
        end
        default: begin
          cell_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_constraint_checker.sv
// Directed and randomized grids checked against a set-based reference model of the sudoku rules.
module tb_sudoku_constraint_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] err_kind;
  logic [3:0] err_row;
  logic [3:0] err_col;
  logic [6:0] cell_count;

  int checks = 0;
  int errors = 0;

  int grid [81];
  int m_kind;
  int m_row;
  int m_col;
  int m_first;

  sudoku_constraint_checker_if #(.VAL_W(4)) cif ();

  sudoku_constraint_checker #(.VAL_W(4), .N_CELLS(81)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cell_if    (cif.slave),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_kind   (err_kind),
    .err_row    (err_row),
    .err_col    (err_col),
    .cell_count (cell_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk cells in order, remembering which digits each row/col/box has seen
  function automatic void model();
    bit sr [9][10];
    bit sc [9][10];
    bit sb [9][10];
    int r, c, b, val, k;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 10; j++) begin
        sr[i][j] = 0; sc[i][j] = 0; sb[i][j] = 0;
      end
    m_kind = 0; m_row = 0; m_col = 0; m_first = -1;
    for (int i = 0; i < 81; i++) begin
      r = i / 9; c = i % 9; b = (r / 3) * 3 + c / 3;
      val = grid[i];
      k = 0;
      if (val >= 10) k = 4;
      else if (val == 0) begin
`ifdef SUDOKU_FULL_EN
        k = 5;
`else
        k = 0;
`endif
      end else begin
        if (sr[r][val]) k = 1;
        else if (sc[c][val]) k = 2;
        else if (sb[b][val]) k = 3;
        sr[r][val] = 1; sc[c][val] = 1; sb[b][val] = 1;
      end
      if (k != 0 && m_first < 0) begin
        m_kind = k; m_row = r; m_col = c; m_first = i;
      end
    end
  endfunction

  // Random solved grid: shifted-pattern base, digit relabelling, rows reordered inside bands
  task automatic base_grid();
    int p [9];
    int rs [9] = '{0, 1, 2, 3, 5, 4, 8, 7, 6};
    int j, t, s;
    for (int i = 0; i < 9; i++) p[i] = i + 1;
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int r = 0; r < 9; r++) begin
      s = rs[r];
      for (int c = 0; c < 9; c++) grid[r * 9 + c] = p[(s * 3 + s / 3 + c) % 9];
    end
  endtask

  task automatic push(input int val);
    logic rdy;
    bit   ok = 0;
    cif.cell_valid = 1'b1;
    cif.cell_value = 4'(val);
    for (int t = 0; t < 50; t++) begin
      rdy = cif.cell_ready;
      tick();
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    cif.cell_valid = 1'b0;
    if (!ok) check("handshake_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_grid(input string tag, input int gap_pct);
    int n;
    model();
    for (int i = 0; i < 81; i++) begin
      n = 0;
      while (gap_pct > 0 && n < 4 && $urandom_range(99) < gap_pct) begin
        cif.cell_valid = 1'b0;
        tick();
        n++;
      end
      push(grid[i]);
      check({tag, "_count"}, cell_count, i + 1);
      check({tag, "_err_prog"}, err, (m_first >= 0 && i >= m_first) ? 1 : 0);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, cif.cell_ready, 0);
    check({tag, "_kind"}, err_kind, m_kind);
    check({tag, "_row"}, err_row, m_row);
    check({tag, "_col"}, err_col, m_col);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_kind"}, err_kind, 0);
    check({tag, "_row"}, err_row, 0);
    check({tag, "_col"}, err_col, 0);
    check({tag, "_count"}, cell_count, 0);
    check({tag, "_ready"}, cif.cell_ready, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cif.cell_valid = 1'b0;
    cif.cell_value = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle_zero("reset");

    // Cells offered in IDLE are ignored
    cif.cell_valid = 1'b1;
    cif.cell_value = 4'd3;
    repeat (3) tick();
    cif.cell_valid = 1'b0;
    check("idle_ignore_count", cell_count, 0);

    // Valid solved grid, back to back
    pulse_start();
    check("start_busy", busy, 1);
    check("start_ready", cif.cell_ready, 1);
    base_grid();
    run_grid("valid", 0);
    check("valid_err", err, 0);
    check("valid_count", cell_count, 81);
    tick();
    check("valid_done_held", done, 1);

    // Row duplicate at (0,4)
    pulse_start();
    base_grid();
    grid[4] = grid[0];
    run_grid("rowdup", 0);
    check("rowdup_kind_c", err_kind, 1);
    check("rowdup_row_c", err_row, 0);
    check("rowdup_col_c", err_col, 4);

    // Column duplicate at (6,2)
    pulse_start();
    base_grid();
    grid[6 * 9 + 2] = grid[2];
    run_grid("coldup", 0);
    check("coldup_kind_c", err_kind, 2);
    check("coldup_row_c", err_row, 6);
    check("coldup_col_c", err_col, 2);

    // Box duplicate at (4,5), box 4
    pulse_start();
    base_grid();
    grid[4 * 9 + 5] = grid[3 * 9 + 3];
    run_grid("boxdup", 0);
    check("boxdup_kind_c", err_kind, 3);
    check("boxdup_row_c", err_row, 4);
    check("boxdup_col_c", err_col, 5);

    // Illegal value at cell 40 followed by a later row duplicate
    pulse_start();
    base_grid();
    grid[40] = 12;
    grid[5 * 9 + 0] = grid[5 * 9 + 1];
    run_grid("illegal", 0);
    check("illegal_kind_c", err_kind, 4);
    check("illegal_row_c", err_row, 4);
    check("illegal_col_c", err_col, 4);

    // Gapped delivery of a clean grid
    pulse_start();
    base_grid();
    run_grid("gap_valid", 40);
    check("gap_valid_err", err, 0);

    // Randomized corrupted grids with gaps
    for (int it = 0; it < 4; it++) begin
      pulse_start();
      base_grid();
      for (int k = 0; k < 3; k++) grid[$urandom_range(80)] = $urandom_range(15);
      run_grid("rand", 30);
    end

    // Reset mid-scan
    pulse_start();
    base_grid();
    for (int i = 0; i < 30; i++) push(grid[i]);
    check("mid_count", cell_count, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrst");
    cif.cell_valid = 1'b1;
    repeat (2) tick();
    cif.cell_valid = 1'b0;
    check("midrst_idle_count", cell_count, 0);

    // Restart after 50 cells, then a full valid grid
    pulse_start();
    base_grid();
    for (int i = 0; i < 50; i++) push(grid[i]);
    pulse_start();
    check("restart_count0", cell_count, 0);
    base_grid();
    run_grid("restart", 0);
    check("restart_err", err, 0);

    // start coincident with a handshake drops that cell
    pulse_start();
    base_grid();
    for (int i = 0; i < 10; i++) push(grid[i]);
    start = 1'b1;
    cif.cell_valid = 1'b1;
    cif.cell_value = 4'd12;
    tick();
    start = 1'b0;
    cif.cell_valid = 1'b0;
    check("coinc_count", cell_count, 0);
    check("coinc_err", err, 0);
    run_grid("coinc", 0);
    check("coinc_err_end", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
